// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: opcodes, FSM states and datapath select encodings for the multi-cycle controller
package riscv_mc_pkg;
   localparam logic [6:0] OP_LOAD   = 7'h03;
   localparam logic [6:0] OP_STORE  = 7'h23;
   localparam logic [6:0] OP_R      = 7'h33;
   localparam logic [6:0] OP_I      = 7'h13;
   localparam logic [6:0] OP_JAL    = 7'h6f;
   localparam logic [6:0] OP_JALR   = 7'h67;
   localparam logic [6:0] OP_BRANCH = 7'h63;
   localparam logic [6:0] OP_LUI    = 7'h37;
   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXEC_R, S_EXEC_I,
      S_ALUWB, S_JAL, S_JALR, S_JALR2, S_BRANCH, S_LUI, S_ILLEGAL
   } state_t;
   localparam logic [2:0] IMM_I = 3'b000;
   localparam logic [2:0] IMM_S = 3'b001;
   localparam logic [2:0] IMM_B = 3'b010;
   localparam logic [2:0] IMM_U = 3'b011;
   localparam logic [2:0] IMM_J = 3'b100;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;
   localparam logic [1:0] RES_ALUOUT = 2'b00;
   localparam logic [1:0] RES_DATA   = 2'b01;
   localparam logic [1:0] RES_ALURES = 2'b10;
   localparam logic [1:0] RES_IMM    = 2'b11;
   localparam logic [1:0] SRCA_PC    = 2'b00;
   localparam logic [1:0] SRCA_OLDPC = 2'b01;
   localparam logic [1:0] SRCA_RD1   = 2'b10;
   localparam logic [1:0] SRCB_RD2   = 2'b00;
   localparam logic [1:0] SRCB_IMM   = 2'b01;
   localparam logic [1:0] SRCB_FOUR  = 2'b10;
   // funct3 values the ALU decoder supports for R/I arithmetic
   function automatic logic f3_legal(input logic [2:0] f3);
      return f3 == 3'b000 || f3 == 3'b010 || f3 == 3'b110 || f3 == 3'b111;
   endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps funct3/funct7b5 of an R or I instruction to the ALU operation
module alu_decoder
   import riscv_mc_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       is_rtype,
   output logic [2:0] alu_control
);
   // funct7b5 selects sub only for R-type; for I-type it is an immediate bit
   always_comb
      alu_control = funct3 == 3'b000 ? ((is_rtype && funct7b5) ? ALU_SUB : ALU_ADD) :
                    funct3 == 3'b010 ? ALU_SLT :
                    funct3 == 3'b110 ? ALU_OR  :
                    funct3 == 3'b111 ? ALU_AND : ALU_ADD;
endmodule

// File: rtl/mc_main_controller.sv
// mc_main_controller: Moore control FSM sequencing the multi-cycle RISC-V datapath
module mc_main_controller
   import riscv_mc_pkg::*;
#(
   parameter bit ENABLE_TRAP = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7b5,
   input  logic       Zero,
   input  logic       Neg,
   output logic       PCWrite,
   output logic       AdrSrc,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegWrite,
   output logic [1:0] ResultSrc,
   output logic [1:0] ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUControl,
   output logic [2:0] ImmSrc,
   output logic       illegal
);
   localparam state_t S_BAD = ENABLE_TRAP ? S_ILLEGAL : S_FETCH;
   state_t     state, nxt;
   logic       pc_write, mem_write, ir_write, reg_write;
   logic       taken;
   logic [2:0] dec_alu;
   alu_decoder u_alu_decoder (
      .funct3     (funct3),
      .funct7b5   (funct7b5),
      .is_rtype   (opcode == OP_R),
      .alu_control(dec_alu)
   );
   assign taken = funct3 == 3'b000 ?  Zero :
                  funct3 == 3'b001 ? !Zero :
                  funct3 == 3'b100 ?  Neg  :
                  funct3 == 3'b101 ? !Neg  : 1'b0;
   // enables are squashed while reset is held so no partial write-back escapes
   assign PCWrite  = pc_write  & ~rst;
   assign MemWrite = mem_write & ~rst;
   assign IRWrite  = ir_write  & ~rst;
   assign RegWrite = reg_write & ~rst;
   // state register; reset always restarts at instruction fetch
   always_ff @(posedge clk)
      state <= rst ? S_FETCH : nxt;
   // per-state datapath controls and next-state selection
   always_comb begin
      nxt        = S_FETCH;
      pc_write   = 1'b0;
      AdrSrc     = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      ResultSrc  = RES_ALUOUT;
      ALUSrcA    = SRCA_PC;
      ALUSrcB    = SRCB_RD2;
      ALUControl = ALU_ADD;
      ImmSrc     = IMM_I;
      illegal    = 1'b0;
      case (state)
         S_FETCH: begin
            ir_write  = 1'b1;
            ALUSrcB   = SRCB_FOUR;
            ResultSrc = RES_ALURES;
            pc_write  = 1'b1;
            nxt       = S_DECODE;
         end
         S_DECODE: begin
            ALUSrcA = SRCA_OLDPC;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = opcode == OP_JAL ? IMM_J : IMM_B;
            case (opcode)
               OP_LOAD, OP_STORE: nxt = S_MEMADR;
               OP_R:              nxt = f3_legal(funct3) ? S_EXEC_R : S_BAD;
               OP_I:              nxt = f3_legal(funct3) ? S_EXEC_I : S_BAD;
               OP_JAL:            nxt = S_JAL;
               OP_JALR:           nxt = S_JALR;
               OP_BRANCH:         nxt = S_BRANCH;
               OP_LUI:            nxt = S_LUI;
               default:           nxt = S_BAD;
            endcase
         end
         S_MEMADR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            ImmSrc  = opcode == OP_STORE ? IMM_S : IMM_I;
            nxt     = opcode == OP_STORE ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            AdrSrc = 1'b1;
            nxt    = S_MEMWB;
         end
         S_MEMWB: begin
            ResultSrc = RES_DATA;
            reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            AdrSrc    = 1'b1;
            mem_write = 1'b1;
         end
         S_EXEC_R: begin
            ALUSrcA    = SRCA_RD1;
            ALUControl = dec_alu;
            nxt        = S_ALUWB;
         end
         S_EXEC_I: begin
            ALUSrcA    = SRCA_RD1;
            ALUSrcB    = SRCB_IMM;
            ALUControl = dec_alu;
            nxt        = S_ALUWB;
         end
         S_ALUWB: reg_write = 1'b1;
         S_JAL, S_JALR2: begin
            pc_write = 1'b1;
            ALUSrcA  = SRCA_OLDPC;
            ALUSrcB  = SRCB_FOUR;
            nxt      = S_ALUWB;
         end
         S_JALR: begin
            ALUSrcA = SRCA_RD1;
            ALUSrcB = SRCB_IMM;
            nxt     = S_JALR2;
         end
         S_BRANCH: begin
            ALUSrcA    = SRCA_RD1;
            ALUControl = ALU_SUB;
            pc_write   = taken;
         end
         S_LUI: begin
            ImmSrc    = IMM_U;
            ResultSrc = RES_IMM;
            reg_write = 1'b1;
         end
         S_ILLEGAL: begin
            illegal = 1'b1;
            nxt     = S_ILLEGAL;
         end
         default: nxt = S_FETCH;
      endcase
   end
endmodule

// File: tb/tb_mc_main_controller.sv
// tb_mc_main_controller: random instruction streams checked cycle by cycle against a per-instruction step model
module tb_mc_main_controller;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = 7'h33;
   logic [2:0] funct3 = 3'b000;
   logic       funct7b5 = 1'b0;
   logic       Zero = 1'b0;
   logic       Neg = 1'b0;
   logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal;
   logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
   logic [2:0] ALUControl, ImmSrc;
   logic [17:0] act;
   int n_chk = 0;
   int n_pass = 0;
   localparam logic [17:0] EN_MASK = 18'h2E000;
   mc_main_controller dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
      .Zero(Zero), .Neg(Neg), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
      .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
      .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .illegal(illegal)
   );
   always #5 clk = ~clk;
   assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, ResultSrc, ALUSrcA, ALUSrcB,
                 ALUControl, ImmSrc, illegal};
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask
   function automatic logic [17:0] o(input logic pcw, adr, mw, irw, rw, input logic [1:0] res, sa, sb,
                                     input logic [2:0] alu, imm, input logic ill);
      return {pcw, adr, mw, irw, rw, res, sa, sb, alu, imm, ill};
   endfunction
   function automatic logic [2:0] alu_op(input logic [2:0] f3, input logic f7, input logic r);
      case (f3)
         3'd0:    return (r && f7) ? 3'b001 : 3'b000;
         3'd2:    return 3'b101;
         3'd6:    return 3'b011;
         default: return 3'b010;
      endcase
   endfunction
   // runs one instruction from FETCH; abort_at >= 0 pulses reset at that step, -2 picks a random step
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic z, input logic n, input int abort_at);
      logic [17:0] q[$];
      logic [17:0] fetch, aluwb, ill_v, e;
      bit bad;
      bit tk;
      int ab;
      opcode = op; funct3 = f3; funct7b5 = f7; Zero = z; Neg = n;
      fetch = o(1,0,0,1,0,2'd2,2'd0,2'd2,3'd0,3'd0,0);
      aluwb = o(0,0,0,0,1,2'd0,2'd0,2'd0,3'd0,3'd0,0);
      ill_v = o(0,0,0,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,1);
      bad = 0;
      q.push_back(fetch);
      q.push_back(o(0,0,0,0,0,2'd0,2'd1,2'd1,3'd0,(op == 7'h6f) ? 3'd4 : 3'd2,0));
      case (op)
         7'h03: begin
            q.push_back(o(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,3'd0,0));
            q.push_back(o(0,1,0,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,0));
            q.push_back(o(0,0,0,0,1,2'd1,2'd0,2'd0,3'd0,3'd0,0));
         end
         7'h23: begin
            q.push_back(o(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,3'd1,0));
            q.push_back(o(0,1,1,0,0,2'd0,2'd0,2'd0,3'd0,3'd0,0));
         end
         7'h33, 7'h13: begin
            bad = !(f3 == 0 || f3 == 2 || f3 == 6 || f3 == 7);
            if (!bad) begin
               q.push_back(o(0,0,0,0,0,2'd0,2'd2,(op == 7'h33) ? 2'd0 : 2'd1,alu_op(f3, f7, op == 7'h33),3'd0,0));
               q.push_back(aluwb);
            end
         end
         7'h6f: begin
            q.push_back(o(1,0,0,0,0,2'd0,2'd1,2'd2,3'd0,3'd0,0));
            q.push_back(aluwb);
         end
         7'h67: begin
            q.push_back(o(0,0,0,0,0,2'd0,2'd2,2'd1,3'd0,3'd0,0));
            q.push_back(o(1,0,0,0,0,2'd0,2'd1,2'd2,3'd0,3'd0,0));
            q.push_back(aluwb);
         end
         7'h63: begin
            tk = (f3 == 0) ? z : (f3 == 1) ? !z : (f3 == 4) ? n : (f3 == 5) ? !n : 1'b0;
            q.push_back(o(tk,0,0,0,0,2'd0,2'd2,2'd0,3'd1,3'd0,0));
         end
         7'h37: q.push_back(o(0,0,0,0,1,2'd3,2'd0,2'd0,3'd0,3'd3,0));
         default: bad = 1;
      endcase
      if (bad) begin
         for (int k = 0; k < 3; k++) q.push_back(ill_v);
         ab = q.size();
      end else
         ab = (abort_at == -2) ? int'($urandom_range(1, q.size() - 1)) : abort_at;
      for (int i = 0; i < q.size() + (bad ? 1 : 0); i++) begin
         e = (i < q.size()) ? q[i] : ill_v;
         if (i == ab) begin
            rst = 1'b1;
            e = e & ~EN_MASK;
         end
         @(negedge clk);
         chk($sformatf("op%02h f3=%0d step%0d%s", op, f3, i, (i == ab) ? " rst" : ""), act, e);
         @(posedge clk);
         #1;
         if (i == ab) begin
            rst = 1'b0;
            break;
         end
      end
   endtask
   initial begin
      logic [6:0] ops [8];
      logic [6:0] op;
      ops = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h6f, 7'h67, 7'h63, 7'h37};
      rst = 1'b1;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("reset enables", act & EN_MASK, 18'h0);
      chk("reset fetch selects", act, 18'h01100);
      @(posedge clk);
      #1;
      rst = 1'b0;
      run_instr(7'h03, 3'd2, 1'b0, 1'b0, 1'b0, -1);
      run_instr(7'h23, 3'd2, 1'b0, 1'b0, 1'b0, -1);
      run_instr(7'h33, 3'd0, 1'b1, 1'b0, 1'b0, -1);
      run_instr(7'h13, 3'd0, 1'b1, 1'b0, 1'b0, -1);
      run_instr(7'h63, 3'd0, 1'b0, 1'b1, 1'b0, -1);
      run_instr(7'h63, 3'd1, 1'b0, 1'b1, 1'b0, -1);
      run_instr(7'h63, 3'd4, 1'b0, 1'b0, 1'b1, -1);
      run_instr(7'h6f, 3'd0, 1'b0, 1'b0, 1'b0, -1);
      run_instr(7'h03, 3'd2, 1'b0, 1'b0, 1'b0, 3);
      run_instr(7'h7f, 3'd0, 1'b0, 1'b0, 1'b0, -1);
      run_instr(7'h33, 3'd3, 1'b0, 1'b0, 1'b0, -1);
      for (int t = 0; t < 300; t++) begin
         if ($urandom_range(0, 9) == 0) begin
            do op = 7'($urandom_range(0, 127));
            while (op inside {7'h03, 7'h23, 7'h33, 7'h13, 7'h6f, 7'h67, 7'h63, 7'h37});
         end else
            op = ops[$urandom_range(0, 7)];
         run_instr(op, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? -2 : -1);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
